// File: rtl/mbs_escalonador.sv
// mbs_escalonador: round-robin scheduler sharing one sequential multiplier (mbs) among N requesters.
// One operation at a time: latch operands, pulse start, wait LATENCIA cycles, return product with done.
module mbs_escalonador #(
    parameter int N        = 4,
    parameter int LARGURA  = 8,
    parameter int LATENCIA = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N*LARGURA-1:0]   a_in,
    input  logic [N*LARGURA-1:0]   b_in,
    output logic [N-1:0]           gnt,
    output logic [N-1:0]           done,
    output logic [2*LARGURA-1:0]   produto_out,
    output logic                   ocupado,
    output logic                   mult_start,
    output logic [LARGURA-1:0]     mult_multiplicando,
    output logic [LARGURA-1:0]     mult_multiplicador,
    input  logic [2*LARGURA-1:0]   mult_produto
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(LATENCIA + 1);
    localparam logic [N-1:0] UM = {{(N-1){1'b0}}, 1'b1};
    typedef enum logic [1:0] {OCIOSO, DISPARO, ESPERA, ENTREGA} estado_t;
    estado_t       estado;
    logic [IW-1:0] ponteiro, indice, sel;
    logic [CW-1:0] contador;
    // Scan downward in offset so the nearest set bit at or after the pointer wins.
    always_comb begin
        sel = ponteiro;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ponteiro) + k) % N]) sel = IW'((int'(ponteiro) + k) % N);
    end
    assign ocupado    = estado != OCIOSO;
    assign mult_start = estado == DISPARO;
    assign gnt        = mult_start ? UM << indice : '0;
    assign done       = (estado == ENTREGA) ? UM << indice : '0;
    always_ff @(posedge clock) begin
        if (reset) begin
            estado             <= OCIOSO;
            ponteiro           <= '0;
            indice             <= '0;
            contador           <= '0;
            mult_multiplicando <= '0;
            mult_multiplicador <= '0;
            produto_out        <= '0;
        end else begin
            case (estado)
                OCIOSO: if (|req) begin
                    estado             <= DISPARO;
                    indice             <= sel;
                    mult_multiplicando <= a_in[int'(sel)*LARGURA +: LARGURA];
                    mult_multiplicador <= b_in[int'(sel)*LARGURA +: LARGURA];
                end
                DISPARO: begin
                    estado   <= ESPERA;
                    contador <= CW'(LATENCIA);
                end
                ESPERA: begin
                    contador <= contador - 1'b1;
                    if (contador == CW'(1)) begin
                        produto_out <= mult_produto;
                        estado      <= ENTREGA;
                    end
                end
                default: begin
                    estado   <= OCIOSO;
                    ponteiro <= (int'(indice) == N - 1) ? '0 : indice + 1'b1;
                end
            endcase
        end
    end
endmodule
